data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the TX byte FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_write  input  1  store strobe from the processor, sampled at the rising edge of clk.
REQ-006 SHALL have port addr  input  32  byte address (the processor's alu_result); addr[1:0] ignored.
REQ-007 SHALL have port write_data  input  32  store data.
REQ-008 SHALL have port read_data  output  32  load data, combinational from addr and current state.
REQ-009 SHALL have port leds  output  8  LED register contents.
REQ-010 SHALL have port tx_valid  output  1  high while the FIFO is non-empty.
REQ-011 SHALL have port tx_data  output  8  FIFO head byte; valid only while tx_valid is high.
REQ-012 SHALL have port tx_ready  input  1  consumer accepts the head byte at a rising edge where tx_valid && tx_ready.

Function
REQ-013 SHALL decode addr[31]=0 as RAM, with word index addr[log2(RAM_WORDS)+1:2]; higher bits ignored (aliasing).
REQ-014 SHALL perform a RAM read combinationally with zero-cycle latency; a RAM write SHALL update the addressed word at the rising edge where mem_write=1.
REQ-015 SHALL decode addr[31]=1 with addr[30:4]=0 as MMIO: 0x80000000 LED, 0x80000004 CYCLE, 0x80000008 TXDATA, 0x8000000C STATUS.
REQ-016 SHALL treat every other addr[31]=1 address as unmapped: read_data=0, writes ignored.
REQ-017 SHALL, for LED writes, load write_data[7:0]; reads SHALL return {24'b0, leds}.
REQ-018 SHALL increment CYCLE by 1 every clock, wrapping 0xFFFFFFFF->0; CYCLE SHALL be read-only and writes to it ignored.
REQ-019 SHALL, for TXDATA writes, push write_data[7:0] into the FIFO; TXDATA reads SHALL return 0.
REQ-020 SHALL return STATUS = {29'b0, overflow, empty, full}: bit0 full, bit1 empty, bit2 overflow.
REQ-021 SHALL clear overflow on a STATUS write with write_data[2]=1; other STATUS write bits ignored.
REQ-022 SHALL pop the head entry at every rising edge with tx_valid && tx_ready.
REQ-023 SHALL accept a push when the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-024 SHALL discard a push while full with no same-cycle pop, leave FIFO contents unchanged, and set overflow at that edge.
REQ-025 SHALL perform a simultaneous push and pop on a non-empty FIFO with the occupancy unchanged; a push into an empty FIFO SHALL make tx_valid high the next cycle (no bypass).
REQ-026 SHALL make overflow sticky until cleared per REQ-021 or reset; if set and cleared in the same cycle, set SHALL win.
REQ-027 SHALL let FIFO read/write pointers wrap modulo FIFO_DEPTH, with occupancy 0..FIFO_DEPTH tracked exactly.
REQ-028 SHALL hold tx_data stable while tx_valid && !tx_ready.
REQ-029 SHALL make all register reads reflect pre-edge state; a same-cycle store is visible on read_data from the following cycle.

Reset
REQ-030 SHALL, on reset assertion, immediately and independent of clk, set leds=0, CYCLE=0, FIFO empty (tx_valid=0), overflow=0.
REQ-031 SHALL leave RAM contents unchanged by reset and ignore stores while reset is high.
REQ-032 SHALL hold CYCLE at 0 while reset is high; it SHALL reach 1 at the first rising edge after deassertion.
REQ-033 SHALL, on reset mid-transfer, discard all queued bytes and drop tx_valid asynchronously.

Verification
REQ-034 SHALL cover a RAM store then load: write 0xDEADBEEF to 0x00000010 -> read of 0x00000010 next cycle = 0xDEADBEEF; read of 0x00000410 (alias) = 0xDEADBEEF.
REQ-035 SHALL cover LED and unmapped access: write 0x1A5 to 0x80000000 -> leds=0xA5, read=0x000000A5; write to 0x80000010 -> no state change, read=0.
REQ-036 SHALL cover FIFO overflow: tx_ready=0, push 0x41..0x45 -> STATUS=0x5 (full and overflow); drain yields 0x41,0x42,0x43,0x44 then tx_valid=0 with STATUS=0x6; write 0x4 to STATUS -> STATUS=0x2.
REQ-037 SHALL cover simultaneous push and pop: FIFO full, tx_ready=1, push 0x55 -> no overflow, occupancy stays 4, 0x55 emerges fourth.
REQ-038 SHALL cover the counter: reset released, after 10 edges CYCLE reads 10; preload model from 0xFFFFFFFE -> wraps to 0 after 2 edges.
REQ-039 SHALL cover asynchronous reset: assert reset between edges with 3 bytes queued -> tx_valid=0, leds=0, STATUS=0x2 before the next edge; RAM word at 0x10 retains its value.

Source files
------------

// File: rtl/data_mem_mmio.sv
// Data memory with memory-mapped LED, free-running cycle counter and a
// byte-wide TX FIFO with sticky overflow flag.
module data_mem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [31:0] r_mem [RAM_WORDS];
  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [7:0]  r_leds;
  logic [31:0] r_cycle;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_ovf;

  logic [AW-1:0] w_word_idx;
  logic          w_mmio_hit;
  logic          w_ram_we;
  logic          w_led_we;
  logic          w_push_req;
  logic          w_ovf_clr;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_push_drop;
  logic          w_unused;

  // Address decode: RAM aliases on the low word-index bits; MMIO needs addr[30:4]==0
  assign w_word_idx  = addr[AW+1:2];
  assign w_mmio_hit  = addr[31] && (addr[30:4] == 27'd0);
  assign w_ram_we    = mem_write && !addr[31] && !reset;
  assign w_led_we    = mem_write && w_mmio_hit && (addr[3:2] == REG_LED);
  assign w_push_req  = mem_write && w_mmio_hit && (addr[3:2] == REG_TXDATA);
  assign w_ovf_clr   = mem_write && w_mmio_hit && (addr[3:2] == REG_STATUS) && write_data[2];
  assign w_unused    = ^addr[1:0];

  // FIFO handshake: a pop frees a slot so a push while full still lands
  assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && tx_ready;
  assign w_push_ok   = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && w_full && !w_pop;

  assign leds     = r_leds;
  assign tx_valid = !w_empty;
  assign tx_data  = r_fifo[r_rptr];

  // Combinational load path reflecting pre-edge state
  always_comb begin
    read_data = 32'd0;
    if (!addr[31]) begin
      read_data = r_mem[w_word_idx];
    end else if (w_mmio_hit) begin
      case (addr[3:2])
        REG_LED:    read_data = {24'd0, r_leds};
        REG_CYCLE:  read_data = r_cycle;
        REG_TXDATA: read_data = 32'd0;
        REG_STATUS: read_data = {29'd0, r_ovf, w_empty, w_full};
        default:    read_data = 32'd0;
      endcase
    end
  end

  // RAM storage: not reset, stores suppressed while reset is high
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_word_idx] <= write_data;
    end
  end

  // FIFO storage array (data only, contents meaningless when empty)
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_fifo[r_wptr] <= write_data[7:0];
    end
  end

  // LED register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= 8'd0;
    end else if (w_led_we) begin
      r_leds <= write_data[7:0];
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap since depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_push_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LED, unmapped, FIFO, counter, reset.
module tb_data_mem_mmio;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_checks;
  int n_fail;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  data_mem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .leds       (leds),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store cycle; returns 1 time unit after the capturing edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    write_data = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, read_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    mem_write = 1'b0;
    addr = 32'd0;
    write_data = 32'd0;
    tx_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_txvalid", {31'd0, tx_valid}, 32'd0);
    rd("rst_status", A_STATUS, 32'h2);
    rd("rst_cycle_held", A_CYCLE, 32'd0);

    // Counter: 10 edges after release
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rd("cycle_10", A_CYCLE, 32'd10);

    // RAM store/load and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
    wr(32'h0000_0020, 32'h1111_1111);
    addr = 32'h0000_0020;
    write_data = 32'h2222_2222;
    mem_write = 1'b1;
    #1;
    chk("ram_pre_edge", read_data, 32'h1111_1111);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    chk("ram_post_edge", read_data, 32'h2222_2222);

    // LED and unmapped
    wr(A_LED, 32'h0000_01A5);
    chk("led_out", {24'd0, leds}, 32'hA5);
    rd("led_read", A_LED, 32'h0000_00A5);
    wr(32'h8000_0010, 32'hFFFF_FFFF);
    chk("unmapped_led", {24'd0, leds}, 32'hA5);
    rd("unmapped_read", 32'h8000_0010, 32'd0);
    rd("txdata_read", A_TXDATA, 32'd0);

    // Overflow: five pushes into a depth-4 FIFO with no consumer
    tx_ready = 1'b0;
    addr = A_TXDATA;
    write_data = 32'h41;
    mem_write = 1'b1;
    #1;
    chk("nobypass_pre", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    chk("nobypass_post", {31'd0, tx_valid}, 32'd1);
    for (int i = 1; i < 5; i++) wr(A_TXDATA, 32'h41 + i);
    rd("ovf_status", A_STATUS, 32'h5);
    @(posedge clk);
    #1;
    chk("hold_data", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", {31'd0, tx_valid}, 32'd1);
      chk("drain_data", {24'd0, tx_data}, 32'h41 + i);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    chk("drained_valid", {31'd0, tx_valid}, 32'd0);
    rd("drained_status", A_STATUS, 32'h6);
    wr(A_STATUS, 32'h4);
    rd("ovf_cleared", A_STATUS, 32'h2);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h51 + i);
    rd("full_status", A_STATUS, 32'h1);
    tx_ready = 1'b1;
    addr = A_TXDATA;
    write_data = 32'h55;
    mem_write = 1'b1;
    #1;
    chk("pp_head", {24'd0, tx_data}, 32'h51);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    tx_ready = 1'b0;
    rd("pp_status", A_STATUS, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pp_drain", {24'd0, tx_data}, 32'h52 + i);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    chk("pp_empty", {31'd0, tx_valid}, 32'd0);

    // Asynchronous reset with bytes queued
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h61 + i);
    chk("queued_valid", {31'd0, tx_valid}, 32'd1);
    addr = A_STATUS;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_txvalid", {31'd0, tx_valid}, 32'd0);
    chk("arst_leds", {24'd0, leds}, 32'd0);
    chk("arst_status", read_data, 32'h2);
    rd("arst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0010, 32'h0);
    rd("rst_store_ignored", 32'h0000_0010, 32'hDEAD_BEEF);
    reset = 1'b0;

    // Counter wrap from a preloaded value
    @(posedge clk);
    #1;
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    rd("cycle_preload", A_CYCLE, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rd("cycle_wrap", A_CYCLE, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
